// File: rtl/float_sub_seq_if.sv
// Operand/result handshake bundle for the sequential binary16 subtractor.
// master drives operands and out_ready; slave is the subtractor.
interface float_sub_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] floatA;
    logic [15:0] floatB;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;

    modport master (
        output in_valid, floatA, floatB, out_ready,
        input  in_ready, out_valid, diff
    );

    modport slave (
        input  in_valid, floatA, floatB, out_ready,
        output in_ready, out_valid, diff
    );
endinterface

// File: rtl/float_sub_seq.sv
// Multi-cycle binary16 subtractor, diff = floatA - floatB.
// One op in flight; alignment and normalization move one bit per cycle.
module float_sub_seq #(
    parameter int MAX_ALIGN = 13
) (
    input  logic           clk,
    input  logic           rst_n,
    float_sub_seq_if.slave io
);
    typedef enum logic [2:0] {
        IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE
    } state_t;

    localparam logic [4:0] MAX_A = 5'(MAX_ALIGN);

    state_t             state_q, state_d;
    logic [15:0]        a_q, a_d;
    logic [15:0]        b_q, b_d;
    logic               sign_q, sign_d;
    logic               sub_q, sub_d;
    logic               big_q, big_d;
    logic signed [6:0]  exp_q, exp_d;
    logic [14:0]        mx_q, mx_d;
    logic [14:0]        my_q, my_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [15:0]        diff_q, diff_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic               a_nan, b_nan, a_inf, b_inf;
    logic               a_zero, b_zero, a_ge;
    logic               spec_w;
    logic [15:0]        spec_val_w;
    logic [14:0]        x_w, y_w;
    logic [4:0]         d_w;
    logic [14:0]        sum_w;
    logic               rnd_w;
    logic [11:0]        mant_w;
    logic signed [6:0]  rexp_w;

    assign a_nan  = (&a_q[14:10]) & (|a_q[9:0]);
    assign b_nan  = (&b_q[14:10]) & (|b_q[9:0]);
    assign a_inf  = (&a_q[14:10]) & ~(|a_q[9:0]);
    assign b_inf  = (&b_q[14:10]) & ~(|b_q[9:0]);
    assign a_zero = ~(|a_q[14:10]);
    assign b_zero = ~(|b_q[14:10]);
    assign a_ge   = a_q[14:0] >= b_q[14:0];
    assign x_w    = a_ge ? a_q[14:0] : b_q[14:0];
    assign y_w    = a_ge ? b_q[14:0] : a_q[14:0];
    assign d_w    = x_w[14:10] - y_w[14:10];

    // Working sig: [14] carry, [13:3] sig with hidden 1, [2:0] G/R/S.
    assign sum_w  = sub_q ? (mx_q - my_q) : (mx_q + my_q);
    assign rnd_w  = mx_q[2] & (mx_q[1] | mx_q[0] | mx_q[3]);
    assign mant_w = {1'b0, mx_q[13:3]} + {11'b0, rnd_w};
    assign rexp_w = mant_w[11] ? (exp_q + 7'sd1) : exp_q;

    // b_q already carries the inverted sign, so this is an effective add.
    always_comb begin
        spec_w     = 1'b1;
        spec_val_w = 16'h0000;
        if (a_nan || b_nan)
            spec_val_w = 16'h7E00;
        else if (a_inf && b_inf)
            spec_val_w = (a_q[15] != b_q[15]) ? 16'h7E00 : a_q;
        else if (a_inf)
            spec_val_w = a_q;
        else if (b_inf)
            spec_val_w = b_q;
        else if (b_zero)
            spec_val_w = a_zero ? {a_q[15], 15'h0000} : a_q;
        else if (a_zero)
            spec_val_w = b_q;
        else if (a_q[14:0] == b_q[14:0] && a_q[15] != b_q[15])
            spec_val_w = 16'h0000;
        else
            spec_w = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sign_d      = sign_q;
        sub_d       = sub_q;
        big_d       = big_q;
        exp_d       = exp_q;
        mx_d        = mx_q;
        my_d        = my_q;
        cnt_d       = cnt_q;
        diff_d      = diff_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (io.in_valid && in_ready_q) begin
                    a_d        = io.floatA;
                    b_d        = {~io.floatB[15], io.floatB[14:0]};
                    in_ready_d = 1'b0;
                    state_d    = UNPACK;
                end
            end
            UNPACK: begin
                if (spec_w) begin
                    a_d     = spec_val_w;
                    state_d = DONE;
                end else begin
                    sign_d  = a_ge ? a_q[15] : b_q[15];
                    sub_d   = a_q[15] ^ b_q[15];
                    exp_d   = {2'b00, x_w[14:10]};
                    mx_d    = {2'b01, x_w[9:0], 3'b000};
                    my_d    = {2'b01, y_w[9:0], 3'b000};
                    big_d   = d_w > MAX_A;
                    cnt_d   = (d_w > MAX_A) ? MAX_A : d_w;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (cnt_q != 5'd0) begin
                    my_d  = {1'b0, my_q[14:2], my_q[1] | my_q[0]};
                    cnt_d = cnt_q - 5'd1;
                end else begin
                    if (big_q)
                        my_d = {14'b0, |my_q};
                    state_d = ADD;
                end
            end
            ADD: begin
                if (sum_w[14]) begin
                    mx_d  = {1'b0, sum_w[14:2], sum_w[1] | sum_w[0]};
                    exp_d = exp_q + 7'sd1;
                end else begin
                    mx_d = sum_w;
                end
                state_d = NORM;
            end
            NORM: begin
                if (!mx_q[13] && mx_q != 15'd0) begin
                    mx_d  = {mx_q[13:0], 1'b0};
                    exp_d = exp_q - 7'sd1;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (rexp_w >= 7'sd31)
                    diff_d = {sign_q, 5'h1F, 10'h000};
                else if (rexp_w < 7'sd1)
                    diff_d = {sign_q, 15'h0000};
                else
                    diff_d = {sign_q, rexp_w[4:0],
                              mant_w[11] ? mant_w[10:1] : mant_w[9:0]};
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                // Special results arrive here with out_valid still low.
                if (!out_valid_q) begin
                    diff_d      = a_q;
                    out_valid_d = 1'b1;
                end else if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            sign_q      <= 1'b0;
            sub_q       <= 1'b0;
            big_q       <= 1'b0;
            exp_q       <= 7'sd0;
            mx_q        <= 15'd0;
            my_q        <= 15'd0;
            cnt_q       <= 5'd0;
            diff_q      <= 16'h0000;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sign_q      <= sign_d;
            sub_q       <= sub_d;
            big_q       <= big_d;
            exp_q       <= exp_d;
            mx_q        <= mx_d;
            my_q        <= my_d;
            cnt_q       <= cnt_d;
            diff_q      <= diff_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.diff      = diff_q;
endmodule

// File: tb/tb_float_sub_seq.sv
// Directed bench for float_sub_seq: vector table plus hold/reset sequences.
// Expected diffs and latencies are hand-computed binary16 results.
module tb_float_sub_seq;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    float_sub_seq_if io ();

    float_sub_seq #(.MAX_ALIGN(13)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_diff;
        int          exp_lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string nm, input int id,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, id, act, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input int id);
        int w;
        w = 0;
        while (io.in_ready !== 1'b1 && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("in_ready_wait", id, {31'b0, io.in_ready}, 32'd1);
        io.floatA   = a;
        io.floatB   = b;
        io.in_valid = 1'b1;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_diff, input int exp_lat,
                          input int id, input bit release_out);
        int lat;
        start_op(a, b, id);
        lat = 0;
        while (io.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("out_valid", id, {31'b0, io.out_valid}, 32'd1);
        check("diff", id, {16'b0, io.diff}, {16'b0, exp_diff});
        check("latency", id, lat, exp_lat);
        if (release_out) begin
            io.out_ready = 1'b1;
            @(posedge clk);
            #1;
            io.out_ready = 1'b0;
            check("rel_valid", id, {31'b0, io.out_valid}, 32'd0);
            check("rel_ready", id, {31'b0, io.in_ready}, 32'd1);
        end
    endtask

    initial begin
        bit hold_ok;
        bit quiet_ok;
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.floatA    = 16'h0000;
        io.floatB    = 16'h0000;
        io.out_ready = 1'b0;

        vecs[0]  = '{16'h39D2, 16'h35A1, 16'h3603, 7};
        vecs[1]  = '{16'hD0A4, 16'h4BD6, 16'hD29A, 7};
        vecs[2]  = '{16'h0000, 16'h39D2, 16'hB9D2, 2};
        vecs[3]  = '{16'h35A1, 16'h0000, 16'h35A1, 2};
        vecs[4]  = '{16'h39D2, 16'h39D2, 16'h0000, 2};
        vecs[5]  = '{16'h7C00, 16'h7C00, 16'h7E00, 2};
        vecs[6]  = '{16'h7BFF, 16'hFBFF, 16'h7C00, 5};
        vecs[7]  = '{16'h7E00, 16'h3C00, 16'h7E00, 2};
        vecs[8]  = '{16'h4000, 16'h3C00, 16'h3C00, 7};
        vecs[9]  = '{16'h3C00, 16'hBC00, 16'h4000, 5};
        vecs[10] = '{16'h3C00, 16'h4000, 16'hBC00, 7};
        vecs[11] = '{16'h5000, 16'h0400, 16'h5000, 19};
        vecs[12] = '{16'h0500, 16'h0400, 16'h0000, 7};
        vecs[13] = '{16'h3C00, 16'h7C00, 16'hFC00, 2};
        vecs[14] = '{16'h7C00, 16'hFC00, 16'h7C00, 2};
        vecs[15] = '{16'h0400, 16'h03FF, 16'h0400, 2};

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 0, {31'b0, io.in_ready}, 32'd1);
        check("rst_out_valid", 0, {31'b0, io.out_valid}, 32'd0);
        check("rst_diff", 0, {16'b0, io.diff}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_diff,
                   vecs[i].exp_lat, i, 1'b1);

        // Backpressure: result held, new operands ignored.
        run_op(16'h39D2, 16'h35A1, 16'h3603, 7, 100, 1'b0);
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                io.floatA   = 16'h4000;
                io.floatB   = 16'h3C00;
                io.in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            if (io.out_valid !== 1'b1 || io.diff !== 16'h3603 ||
                io.in_ready !== 1'b0)
                hold_ok = 1'b0;
        end
        io.in_valid = 1'b0;
        check("hold", 100, {31'b0, hold_ok}, 32'd1);
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        check("hold_rel_valid", 100, {31'b0, io.out_valid}, 32'd0);
        check("hold_rel_ready", 100, {31'b0, io.in_ready}, 32'd1);
        check("hold_diff_kept", 100, {16'b0, io.diff}, 32'h3603);
        quiet_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1 ||
                io.diff !== 16'h3603)
                quiet_ok = 1'b0;
        end
        check("ignored_op", 100, {31'b0, quiet_ok}, 32'd1);

        // Reset while aligning: outputs clear at once, no stale result.
        start_op(16'h39D2, 16'h35A1, 200);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 200, {31'b0, io.out_valid}, 32'd0);
        check("midrst_ready", 200, {31'b0, io.in_ready}, 32'd1);
        check("midrst_diff", 200, {16'b0, io.diff}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1)
                quiet_ok = 1'b0;
        end
        check("no_stale", 200, {31'b0, quiet_ok}, 32'd1);
        run_op(16'hD0A4, 16'h4BD6, 16'hD29A, 7, 201, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
